i2c_seq_writer: RTL and testbench
=================================

I2C_SEQ_WRITER -- requirements
Module: i2c_seq_writer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, meaning clk cycles per SCL quarter-period (50 MHz -> 100 kHz SCL).
REQ-002 SHALL have parameter MAX_BYTES, default 10, meaning the maximum number of data bytes per transaction (one per equaliser band).
REQ-003 SHALL have parameter CNT_W, default 4, meaning the width of the count input; 2^CNT_W-1 >= MAX_BYTES.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle transaction request; sampled only in IDLE.
REQ-007 SHALL have port slave_addr  input  7  target address; latched when start is accepted.
REQ-008 SHALL have port reg_addr  input  8  first register address; latched when start is accepted.
REQ-009 SHALL have port count  input  CNT_W  number of data bytes; latched on start, clamped to MAX_BYTES.
REQ-010 SHALL have port data_in  input  8  next data byte.
REQ-011 SHALL have port data_valid  input  1  data_in is valid.
REQ-012 SHALL have port data_ready  output  1  block consumes data_in this cycle when data_valid is also 1.
REQ-013 SHALL have port scl  output  1  push-pull SCL.
REQ-014 SHALL have port sda_pull_low  output  1  1 drives SDA low; 0 releases SDA (open-drain).
REQ-015 SHALL have port sda_in  input  1  sampled SDA line level.
REQ-016 SHALL have port busy  output  1  high from start acceptance until the DONE state is left.
REQ-017 SHALL have port done  output  1  one-cycle pulse at the end of a transaction.
REQ-018 SHALL have port nack  output  1  error flag, valid with done, held until the next accepted start.

Function
REQ-019 SHALL implement states IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, FETCH, DATA, DATA_ACK, STOP and DONE.
REQ-020 SHALL split each bit into four quarter-phases of CLK_DIV cycles: Q0 (SCL low, SDA updated at its first cycle), Q1 (SCL low), Q2 (SCL high), Q3 (SCL high).
REQ-021 SHALL sample sda_in on the last clk cycle of Q2 in every ACK bit, and release SDA for the whole ACK bit.
REQ-022 SHALL generate START in the START state as follows: SDA released and SCL high for 2 quarters, then SDA low with SCL high for 1 quarter, then SCL low for 1 quarter.
REQ-023 SHALL generate STOP in the STOP state as follows: SDA low and SCL low for 1 quarter, SCL high for 1 quarter, then SDA released for 2 quarters.
REQ-024 SHALL send bytes MSB first; ADDR sends {slave_addr,1'b0}; REG sends reg_addr.
REQ-025 SHALL transition REG_ACK to STOP when count is 0, and otherwise to FETCH.
REQ-026 SHALL, in FETCH, assert data_ready and hold SCL low until data_valid=1; when data_valid=1, latch data_in and go to DATA the next cycle; data_ready SHALL never assert outside FETCH.
REQ-027 SHALL transition DATA_ACK to FETCH while bytes_sent < count, and otherwise to STOP.
REQ-028 SHALL, on any ACK bit sampled high (NACK), set nack=1, go to STOP, and consume no further data bytes.
REQ-029 SHALL hold DONE for exactly one cycle with done=1 and then return to IDLE; busy SHALL fall with the return to IDLE.
REQ-030 SHALL ignore start while busy=1, and SHALL accept a start asserted in the first IDLE cycle after DONE.
REQ-031 SHALL load the bit counter with 7 and the byte counter with 0 on start acceptance.

Reset
REQ-032 SHALL, while rst_n=0 and regardless of cycle phase, force: state=IDLE, scl=1, sda_pull_low=0, busy=0, done=0, nack=0, data_ready=0, and all counters to 0.
REQ-033 SHALL, on reset asserted mid-transaction, produce no STOP sequence; the bus simply returns to released/high.

Verification
REQ-034 SHALL be verified with: slave_addr=7'h6A, reg_addr=8'h00, count=10, bytes FF,FF,FF,00x7, slave ACKs all -> bus carries D4,00,FF,FF,FF,00..00; nack=0; done pulses once; exactly 10 data_ready handshakes.
REQ-035 SHALL be verified with: count=0 -> only D4,00 sent, then STOP; data_ready never asserted.
REQ-036 SHALL be verified with: slave NACKs the address byte -> STOP follows immediately, nack=1 with done, zero bytes consumed.
REQ-037 SHALL be verified with: data_valid withheld for 500 cycles before byte 3 -> SCL held low throughout; byte 3 transmitted intact afterwards.
REQ-038 SHALL be verified with: rst_n pulsed low during byte 5 -> scl=1 and sda_pull_low=0 within the reset cycle; a new start after reset completes normally.
REQ-039 SHALL be verified with: start re-pulsed while busy, and count=15 with MAX_BYTES=10 -> the re-pulse is ignored; exactly 10 data bytes are sent.

Source files
------------

// File: rtl/i2c_seq_writer.sv
// I2C single-master register writer: START, address, register pointer, then
// up to MAX_BYTES streamed data bytes with slave ACK checking, then STOP.
module i2c_seq_writer #(
    parameter int CLK_DIV   = 125,
    parameter int MAX_BYTES = 10,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       slave_addr,
    input  logic [7:0]       reg_addr,
    input  logic [CNT_W-1:0] count,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             scl,
    output logic             sda_pull_low,
    input  logic             sda_in,
    output logic             busy,
    output logic             done,
    output logic             nack
);

    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK,
        FETCH, DATA, DATA_ACK, STOP, DONE
    } state_t;

    state_t           state, state_nx;
    logic [QW-1:0]    q_cnt;
    logic [1:0]       phase;
    logic [2:0]       bit_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_lat;
    logic [7:0]       shift;
    logic [7:0]       reg_lat;
    logic             ack_bit;
    logic             nack_q;

    logic timed, q_end, bit_end, is_ack, accept;

    assign timed   = state inside {START, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP};
    assign is_ack  = state inside {ADDR_ACK, REG_ACK, DATA_ACK};
    assign q_end   = (q_cnt == QW'(CLK_DIV - 1));
    assign bit_end = timed && q_end && (phase == 2'd3);
    assign accept  = (state == IDLE) && start;

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign nack = nack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Bus levels are decoded from the state and quarter-phase so that reset
    // releases the bus immediately, with no STOP sequence.
    always_comb begin
        state_nx     = state;
        scl          = 1'b1;
        sda_pull_low = 1'b0;
        data_ready   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = START;
            end
            START: begin
                scl          = (phase != 2'd3);
                sda_pull_low = phase[1];
                if (bit_end) state_nx = ADDR;
            end
            ADDR, REG, DATA: begin
                scl          = phase[1];
                sda_pull_low = ~shift[7];
                if (bit_end && bit_cnt == 3'd0) begin
                    case (state)
                        ADDR:    state_nx = ADDR_ACK;
                        REG:     state_nx = REG_ACK;
                        default: state_nx = DATA_ACK;
                    endcase
                end
            end
            ADDR_ACK: begin
                scl = phase[1];
                if (bit_end) state_nx = ack_bit ? STOP : REG;
            end
            REG_ACK: begin
                scl = phase[1];
                if (bit_end) state_nx = (ack_bit || cnt_lat == '0) ? STOP : FETCH;
            end
            DATA_ACK: begin
                scl = phase[1];
                if (bit_end) state_nx = (!ack_bit && byte_cnt < cnt_lat) ? FETCH : STOP;
            end
            FETCH: begin
                scl        = 1'b0;
                data_ready = 1'b1;
                if (data_valid) state_nx = DATA;
            end
            STOP: begin
                scl          = (phase != 2'd0);
                sda_pull_low = ~phase[1];
                if (bit_end) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt    <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= '0;
            cnt_lat  <= '0;
            shift    <= 8'h00;
            reg_lat  <= 8'h00;
            ack_bit  <= 1'b0;
            nack_q   <= 1'b0;
        end else if (accept) begin
            q_cnt    <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd7;
            byte_cnt <= '0;
            cnt_lat  <= (count > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : count;
            shift    <= {slave_addr, 1'b0};
            reg_lat  <= reg_addr;
            nack_q   <= 1'b0;
        end else if (timed) begin
            if (q_end) begin
                q_cnt <= '0;
                phase <= phase + 2'd1;
            end else begin
                q_cnt <= q_cnt + 1'b1;
            end
            // ACK is taken at the end of the first SCL-high quarter
            if (is_ack && phase == 2'd2 && q_end) ack_bit <= sda_in;
            if (bit_end) begin
                case (state)
                    ADDR, REG, DATA: begin
                        if (bit_cnt != 3'd0) begin
                            bit_cnt <= bit_cnt - 3'd1;
                            shift   <= shift << 1;
                        end
                    end
                    ADDR_ACK: begin
                        if (ack_bit) begin
                            nack_q <= 1'b1;
                        end else begin
                            shift   <= reg_lat;
                            bit_cnt <= 3'd7;
                        end
                    end
                    REG_ACK, DATA_ACK: begin
                        if (ack_bit) nack_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (state == FETCH && data_valid) begin
            shift    <= data_in;
            bit_cnt  <= 3'd7;
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2c_seq_writer.sv
// Directed bench for i2c_seq_writer: a bus-level slave model decodes bytes off
// SCL/SDA and checks them against a queue of expected bytes.
module tb_i2c_seq_writer;

    localparam int CLK_DIV   = 4;
    localparam int MAX_BYTES = 10;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       slave_addr = 7'h00;
    logic [7:0]       reg_addr = 8'h00;
    logic [CNT_W-1:0] count = '0;
    logic [7:0]       data_in = 8'h00;
    logic             data_valid = 1'b0;
    logic             data_ready, scl, sda_pull_low, sda_in, busy, done, nack;
    logic             slave_pull = 1'b0;

    assign sda_in = ~(sda_pull_low | slave_pull);

    always #5 clk = ~clk;

    i2c_seq_writer #(
        .CLK_DIV   (CLK_DIV),
        .MAX_BYTES (MAX_BYTES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .slave_addr   (slave_addr),
        .reg_addr     (reg_addr),
        .count        (count),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .scl          (scl),
        .sda_pull_low (sda_pull_low),
        .sda_in       (sda_in),
        .busy         (busy),
        .done         (done),
        .nack         (nack)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] data_q[$];

    int   hs_cnt = 0, done_cnt = 0, stop_cnt = 0, start_cnt = 0;
    int   dr_cnt = 0, dr_bad = 0, unexp_cnt = 0, given = 0;
    int   stall_at = -1, stall_left = 0, stall_seen = 0, stall_bad = 0;
    int   nack_at = -1;
    logic pending = 1'b0;

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endfunction

    // Slave model: detects START/STOP, shifts in bytes on SCL rise, ACKs.
    initial begin : bus_monitor
        logic       pscl, psda, in_xfer;
        logic [7:0] sh;
        int         bitpos, byte_idx;
        pscl = 1'b1; psda = 1'b1; in_xfer = 1'b0; sh = 8'h00;
        bitpos = 0; byte_idx = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_pull = 1'b0;
                bitpos     = 0;
                in_xfer    = 1'b0;
            end else begin
                if (done) done_cnt++;
                if (data_ready) dr_cnt++;
                if (data_ready && scl) dr_bad++;
                if (pscl && scl && psda && !sda_in) begin
                    start_cnt++;
                    in_xfer  = 1'b1;
                    bitpos   = 0;
                    byte_idx = 0;
                end else if (pscl && scl && !psda && sda_in) begin
                    stop_cnt++;
                    in_xfer = 1'b0;
                end else if (!pscl && scl && in_xfer) begin
                    if (bitpos < 8) sh = {sh[6:0], sda_in};
                    bitpos++;
                    if (bitpos == 8) begin
                        if (exp_q.size() == 0) unexp_cnt++;
                        else chk("bus_byte", 32'(sh), 32'(exp_q.pop_front()));
                    end
                end else if (pscl && !scl && in_xfer) begin
                    if (bitpos == 8) begin
                        slave_pull = (byte_idx != nack_at);
                    end else if (bitpos == 9) begin
                        slave_pull = 1'b0;
                        bitpos     = 0;
                        byte_idx++;
                    end
                end
            end
            pscl = scl;
            psda = ~(sda_pull_low | slave_pull);
        end
    end

    // Data source: offers data_q[0]; a handshake seen at a falling edge is
    // consumed on the following rising edge.
    initial begin : data_source
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending    = 1'b0;
                data_valid = 1'b0;
            end else begin
                if (pending) begin
                    data_q.delete(0);
                    given++;
                    pending = 1'b0;
                end
                data_valid = (data_q.size() > 0);
                data_in    = (data_q.size() > 0) ? data_q[0] : 8'h00;
                if (data_valid && data_ready && given == stall_at && stall_left > 0) begin
                    data_valid = 1'b0;
                    stall_left--;
                    stall_seen++;
                    if (scl) stall_bad++;
                end
                if (data_valid && data_ready) begin
                    hs_cnt++;
                    pending = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        hs_cnt = 0; done_cnt = 0; stop_cnt = 0; start_cnt = 0;
        dr_cnt = 0; dr_bad = 0; unexp_cnt = 0; given = 0;
        stall_seen = 0; stall_bad = 0;
    endtask

    task automatic pulse_start(input logic [6:0] a, input logic [7:0] r, input logic [CNT_W-1:0] c);
        @(negedge clk);
        slave_addr = a; reg_addr = r; count = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output logic got, output logic nk);
        got = 1'b0; nk = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                got = 1'b1;
                nk  = nack;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        logic got, nk;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_scl",   32'(scl),          32'd1);
        chk("rst_sda",   32'(sda_pull_low), 32'd0);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);
        chk("rst_nack",  32'(nack),         32'd0);
        chk("rst_ready", 32'(data_ready),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full ten-byte write
        clear_counts();
        exp_q  = '{8'hD4, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        data_q = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        pulse_start(7'h6A, 8'h00, 4'd10);
        chk("t1_busy_after_start", 32'(busy), 32'd1);
        wait_done(4000, got, nk);
        chk("t1_done_seen", 32'(got), 32'd1);
        chk("t1_nack", 32'(nk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_done_pulses", done_cnt, 1);
        chk("t1_handshakes", hs_cnt, 10);
        chk("t1_bytes_left", exp_q.size(), 0);
        chk("t1_extra_bytes", unexp_cnt, 0);
        chk("t1_starts", start_cnt, 1);
        chk("t1_stops", stop_cnt, 1);
        chk("t1_ready_scl_high", dr_bad, 0);

        // Zero-length write
        clear_counts();
        exp_q  = '{8'hD4, 8'h00};
        data_q = '{8'h77};
        pulse_start(7'h6A, 8'h00, 4'd0);
        wait_done(2000, got, nk);
        chk("t2_done_seen", 32'(got), 32'd1);
        chk("t2_nack", 32'(nk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t2_ready_cycles", dr_cnt, 0);
        chk("t2_handshakes", hs_cnt, 0);
        chk("t2_bytes_left", exp_q.size(), 0);
        chk("t2_extra_bytes", unexp_cnt, 0);
        chk("t2_stops", stop_cnt, 1);
        data_q.delete();

        // Address NACK
        clear_counts();
        nack_at = 0;
        exp_q  = '{8'hD4};
        data_q = '{8'h12, 8'h34};
        pulse_start(7'h6A, 8'h05, 4'd2);
        wait_done(2000, got, nk);
        chk("t3_done_seen", 32'(got), 32'd1);
        chk("t3_nack_with_done", 32'(nk), 32'd1);
        repeat (3) @(negedge clk);
        chk("t3_nack_held", 32'(nack), 32'd1);
        chk("t3_handshakes", hs_cnt, 0);
        chk("t3_data_untouched", data_q.size(), 2);
        chk("t3_bytes_left", exp_q.size(), 0);
        chk("t3_extra_bytes", unexp_cnt, 0);
        chk("t3_stops", stop_cnt, 1);
        nack_at = -1;
        data_q.delete();

        // Source stalls 500 cycles before the third data byte
        clear_counts();
        stall_at = 2; stall_left = 500;
        exp_q  = '{8'hD4, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        pulse_start(7'h6A, 8'h08, 4'd5);
        chk("t4_nack_cleared", 32'(nack), 32'd0);
        wait_done(4000, got, nk);
        chk("t4_done_seen", 32'(got), 32'd1);
        chk("t4_nack", 32'(nk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_stall_cycles", stall_seen, 500);
        chk("t4_scl_high_in_stall", stall_bad, 0);
        chk("t4_handshakes", hs_cnt, 5);
        chk("t4_bytes_left", exp_q.size(), 0);
        chk("t4_extra_bytes", unexp_cnt, 0);
        stall_at = -1;

        // Reset in the middle of the fifth data byte
        clear_counts();
        exp_q  = '{8'hD4, 8'h20, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        data_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9};
        pulse_start(7'h6A, 8'h20, 4'd10);
        for (int i = 0; i < 3000 && hs_cnt < 5; i++) @(negedge clk);
        chk("t5_reached_byte5", hs_cnt, 5);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_scl", 32'(scl), 32'd1);
        chk("t5_rst_sda", 32'(sda_pull_low), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(data_ready), 32'd0);
        repeat (3) @(negedge clk);
        exp_q.delete();
        data_q.delete();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_stop_on_reset", stop_cnt, 0);
        clear_counts();
        exp_q  = '{8'hD4, 8'h21, 8'h5A, 8'hA5};
        data_q = '{8'h5A, 8'hA5};
        pulse_start(7'h6A, 8'h21, 4'd2);
        wait_done(2000, got, nk);
        chk("t5_done_seen", 32'(got), 32'd1);
        chk("t5_nack", 32'(nk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t5_handshakes", hs_cnt, 2);
        chk("t5_bytes_left", exp_q.size(), 0);
        chk("t5_done_pulses", done_cnt, 1);

        // count above MAX_BYTES, start re-pulsed while busy
        clear_counts();
        exp_q  = '{8'hD4, 8'h30, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9};
        data_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hB9, 8'hBA, 8'hBB};
        pulse_start(7'h6A, 8'h30, 4'd15);
        repeat (200) @(negedge clk);
        pulse_start(7'h11, 8'h99, 4'd1);
        wait_done(4000, got, nk);
        chk("t6_done_seen", 32'(got), 32'd1);
        chk("t6_nack", 32'(nk), 32'd0);
        repeat (3) @(negedge clk);
        chk("t6_handshakes", hs_cnt, 10);
        chk("t6_data_left", data_q.size(), 2);
        chk("t6_bytes_left", exp_q.size(), 0);
        chk("t6_extra_bytes", unexp_cnt, 0);
        chk("t6_starts", start_cnt, 1);
        chk("t6_done_pulses", done_cnt, 1);
        chk("t6_busy_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
